// File: rtl/top_alu.sv
// 8-bit, 16-function ALU with a registered 16-bit result.
// Combinational opcode decode feeds a single result register; ex_sel picks signed operands.
module top_alu (
  input  logic        clk,
  input  logic        init,
  input  logic [3:0]  opcode_in,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        ex_sel,
  output logic [15:0] Y
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_AND = 4'd3,
    OP_OR   = 4'd4,  OP_XOR  = 4'd5,  OP_NAND = 4'd6,  OP_NOR = 4'd7,
    OP_XNOR = 4'd8,  OP_NOT  = 4'd9,  OP_SHL  = 4'd10, OP_SHR = 4'd11,
    OP_DIV  = 4'd12, OP_INC  = 4'd13, OP_DEC  = 4'd14, OP_CMP = 4'd15
  } op_e;

  op_e         op;
  logic [15:0] a_ext, b_ext;
  logic [15:0] y_next;

  logic [7:0]  shr_val;
  logic [7:0]  a_mag, b_mag, b_div;
  logic [7:0]  q_mag, r_mag, quo, rem;
  logic        gt, lt;

  assign op    = op_e'(opcode_in);
  assign a_ext = ex_sel ? {{8{A[7]}}, A} : {8'h00, A};
  assign b_ext = ex_sel ? {{8{B[7]}}, B} : {8'h00, B};

  // Signed division runs on magnitudes; |-128| = 8'h80 still fits as an unsigned byte.
  always_comb begin
    a_mag = (ex_sel && A[7]) ? 8'(-A) : A;
    b_mag = (ex_sel && B[7]) ? 8'(-B) : B;
    // Divisor forced nonzero so the divider never yields X; B=0 is overridden below.
    b_div = (b_mag == 8'h00) ? 8'h01 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quo   = (ex_sel && (A[7] ^ B[7])) ? 8'(-q_mag) : q_mag;
    rem   = (ex_sel && A[7])          ? 8'(-r_mag) : r_mag;
  end

  always_comb begin
    if (ex_sel) begin
      shr_val = $signed(A) >>> B[2:0];
      gt      = $signed(A) > $signed(B);
      lt      = $signed(A) < $signed(B);
    end else begin
      shr_val = A >> B[2:0];
      gt      = A > B;
      lt      = A < B;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    y_next = 16'h0000;
    case (op)
      OP_ADD:  y_next = a_ext + b_ext;
      OP_SUB:  y_next = a_ext - b_ext;
      OP_MUL:  y_next = a_ext * b_ext;
      OP_AND:  y_next = {8'h00, A & B};
      OP_OR:   y_next = {8'h00, A | B};
      OP_XOR:  y_next = {8'h00, A ^ B};
      OP_NAND: y_next = {8'h00, ~(A & B)};
      OP_NOR:  y_next = {8'h00, ~(A | B)};
      OP_XNOR: y_next = {8'h00, ~(A ^ B)};
      OP_NOT:  y_next = {8'h00, ~A};
      OP_SHL:  y_next = {8'h00, 8'(A << B[2:0])};
      OP_SHR:  y_next = {8'h00, shr_val};
      OP_DIV:  y_next = (B == 8'h00) ? 16'hFFFF : {rem, quo};
      OP_INC:  y_next = a_ext + 16'd1;
      OP_DEC:  y_next = a_ext - 16'd1;
      OP_CMP:  y_next = {13'h0000, lt, ~(gt | lt), gt};
      default: y_next = 16'h0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge init) begin
    if (!init) Y <= 16'h0000;
    else       Y <= y_next;
  end

endmodule

// File: tb/tb_top_alu.sv
// Self-checking bench for top_alu: expected results are queued at drive time
// and compared one edge later by a monitor process.
module tb_top_alu;

  logic        clk = 1'b0;
  logic        init;
  logic [3:0]  opcode_in;
  logic [7:0]  A, B;
  logic        ex_sel;
  logic [15:0] Y;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  top_alu dut (
    .clk(clk), .init(init), .opcode_in(opcode_in),
    .A(A), .B(B), .ex_sel(ex_sel), .Y(Y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Independent reference written with plain integer arithmetic.
  function automatic logic [15:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic ex);
    int sa, sb, r, q, m;
    logic [31:0] rv;
    sa = ex ? int'($signed(a)) : int'(a);
    sb = ex ? int'($signed(b)) : int'(b);
    r  = 0;
    case (op)
      4'd0:  r = sa + sb;
      4'd1:  r = sa - sb;
      4'd2:  r = sa * sb;
      4'd3:  r = int'(a) & int'(b);
      4'd4:  r = int'(a) | int'(b);
      4'd5:  r = int'(a) ^ int'(b);
      4'd6:  r = (~(int'(a) & int'(b))) & 'hFF;
      4'd7:  r = (~(int'(a) | int'(b))) & 'hFF;
      4'd8:  r = (~(int'(a) ^ int'(b))) & 'hFF;
      4'd9:  r = (~int'(a)) & 'hFF;
      4'd10: r = (int'(a) << b[2:0]) & 'hFF;
      4'd11: r = (sa >>> b[2:0]) & 'hFF;
      4'd12: begin
        if (b == 8'h00) r = 'hFFFF;
        else begin
          q = sa / sb;
          m = sa % sb;
          r = ((m & 'hFF) << 8) | (q & 'hFF);
        end
      end
      4'd13: r = sa + 1;
      4'd14: r = sa - 1;
      default: r = (sa > sb) ? 1 : ((sa == sb) ? 2 : 4);
    endcase
    rv = r;
    return rv[15:0];
  endfunction

  task automatic drive(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ex, input logic [15:0] exp);
    @(negedge clk);
    opcode_in = op; A = a; B = b; ex_sel = ex;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic drive_m(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ex);
    drive(tag, op, a, b, ex, model(op, a, b, ex));
  endtask

  always @(posedge clk) begin
    if (init && exp_q.size() > 0) begin
      logic [15:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      #1 check(t, Y, e);
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 16'(exp_q.size()), 16'h0000);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  logic [15:0] sweep_exp[16] = '{16'h0004, 16'h0000, 16'h0004, 16'h0002,
                                 16'h0002, 16'h0000, 16'h00FD, 16'h00FD,
                                 16'h00FF, 16'h00FD, 16'h0008, 16'h0000,
                                 16'h0001, 16'h0003, 16'h0001, 16'h0002};

  initial begin
    init = 1'b0; opcode_in = 4'd0; A = 8'h12; B = 8'h83; ex_sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", Y, 16'h0000);

    // Release: first edge loads 12+83.
    init = 1'b1;
    exp_q.push_back(16'h0095);
    tag_q.push_back("reset_release");
    drain();

    for (int k = 0; k < 32; k++)
      drive("sweep", 4'(k), 8'h02, 8'h02, 1'b0, sweep_exp[k % 16]);

    drive("div0_u",    4'd12, 8'h02, 8'h00, 1'b0, 16'hFFFF);
    drive("div0_s",    4'd12, 8'h02, 8'h00, 1'b1, 16'hFFFF);
    drive("div17_5",   4'd12, 8'd17, 8'd5,  1'b0, 16'h0203);
    drive("mul_u",     4'd2,  8'hFE, 8'h03, 1'b0, 16'h02FA);
    drive("mul_s",     4'd2,  8'hFE, 8'h03, 1'b1, 16'hFFFA);
    drive("cmp_u",     4'd15, 8'hFE, 8'h03, 1'b0, 16'h0001);
    drive("cmp_s",     4'd15, 8'hFE, 8'h03, 1'b1, 16'h0004);
    drive("shr_u",     4'd11, 8'hFE, 8'h01, 1'b0, 16'h007F);
    drive("shr_s",     4'd11, 8'hFE, 8'h01, 1'b1, 16'h00FF);
    drive("add_ff",    4'd0,  8'hFF, 8'hFF, 1'b0, 16'h01FE);
    drive("mul_ff",    4'd2,  8'hFF, 8'hFF, 1'b0, 16'hFE01);
    drive("dec_0",     4'd14, 8'h00, 8'h00, 1'b0, 16'hFFFF);
    drive("div_m128",  4'd12, 8'h80, 8'hFF, 1'b1, 16'h0080);
    drive("div_s_neg", 4'd12, 8'hF9, 8'h02, 1'b1, 16'hFFFD);
    drive("add_s",     4'd0,  8'h80, 8'h01, 1'b1, 16'hFF81);
    drain();

    // Mid-stream reset: Y must clear between edges.
    drive("pre_reset", 4'd0, 8'h01, 8'h01, 1'b0, 16'h0002);
    drain();
    @(posedge clk);
    #3 init = 1'b0;
    #1 check("async_clear", Y, 16'h0000);
    opcode_in = 4'd0; A = 8'h40; B = 8'h40;
    @(posedge clk);
    #1 check("reset_hold2", Y, 16'h0000);
    @(negedge clk);
    init = 1'b1;
    exp_q.push_back(16'h0080);
    tag_q.push_back("release2");
    drain();

    for (int i = 0; i < 400; i++)
      drive_m("rand", 4'($urandom_range(15)), 8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 64; i++)
      drive_m("rand_div", 4'd12, 8'($urandom), 8'($urandom_range(3)), 1'($urandom));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/top_alu.md
Name: top_alu

Overview:
- 8-bit, 16-function ALU with a registered 16-bit result.
- A 4-bit opcode is decoded into one of 16 operations on operands A and B.
- ex_sel selects between unsigned (basic) and signed (extended) interpretation of the arithmetic and compare operations.
- Used as the datapath execution unit; the result is valid one clock after the operands and opcode are presented.

Parameters:
- None. Widths are fixed: operands 8 bits, opcode 4 bits, result 16 bits.

Ports:
- clk  input  1  rising-edge clock
- init  input  1  asynchronous active-low reset; 0 clears Y, 1 is normal operation
- opcode_in  input  4  operation select
- A  input  8  operand A
- B  input  8  operand B
- ex_sel  input  1  0 = unsigned operands, 1 = signed two's-complement operands
- Y  output  16  registered result

Behaviour:
- Reset:
  - init=0 forces Y=16'h0000 immediately, without waiting for clk.
  - Y holds 0 while init=0.
  - On release, the first clk rising edge with init=1 loads a result.
- Timing:
  - On every clk rising edge with init=1: Y <= f(opcode_in, A, B, ex_sel).
  - Latency is 1 cycle. There is no enable or handshake; a new result is produced every cycle.
  - Internal opcode decode and operation logic are purely combinational.
- Operand extension: "ext" means zero-extend to 16 bits when ex_sel=0 and sign-extend when ex_sel=1. All arithmetic results are 16 bits, modulo 2^16.
- Opcode map:
  - 0 ADD: ext(A)+ext(B)
  - 1 SUB: ext(A)-ext(B)
  - 2 MUL: A*B, unsigned or signed per ex_sel; full 16-bit product
  - 3 AND: {8'h00, A&B}
  - 4 OR: {8'h00, A|B}
  - 5 XOR: {8'h00, A^B}
  - 6 NAND: {8'h00, ~(A&B)}
  - 7 NOR: {8'h00, ~(A|B)}
  - 8 XNOR: {8'h00, ~(A^B)}
  - 9 NOT: {8'h00, ~A}
  - 10 SHL: {8'h00, A << B[2:0]}; bits shifted beyond bit 7 are discarded
  - 11 SHR: A >> B[2:0], within 8 bits, result in Y[7:0]; logical when ex_sel=0, arithmetic when ex_sel=1; Y[15:8]=0
  - 12 DIV:
    - Y[7:0] = quotient, Y[15:8] = remainder.
    - Unsigned when ex_sel=0.
    - When ex_sel=1: signed, quotient truncated toward zero, remainder takes the sign of A.
    - B=0 gives Y=16'hFFFF regardless of ex_sel.
    - Signed -128/-1 gives quotient 8'h80, remainder 0.
  - 13 INC: ext(A)+1
  - 14 DEC: ext(A)-1
  - 15 CMP:
    - Y[0]=A>B, Y[1]=A==B, Y[2]=A<B, Y[15:3]=0.
    - Signedness per ex_sel.
    - Exactly one of Y[2:0] is set.
- ex_sel has no effect on opcodes 3–10.
- Inputs that change between edges have no effect on Y until the next edge.
- Asserting reset mid-stream discards the pending result; Y=0 until the first edge after release.
- No X propagation: every opcode/ex_sel combination produces a defined value.

Test Plan:
- Reset: init=0 with A=8'h12, B=8'h83, opcode=0, clocking -> Y=16'h0000. Release init=1 -> after 1 edge Y=16'h0095.
- Opcode sweep: A=B=8'h02, ex_sel=0, opcode_in incremented 0..15 one per cycle -> Y sequence (each one cycle late):
  - opcodes 0–7: 0004, 0000, 0004, 0002, 0002, 0000, 00FD, 00FD
  - opcodes 8–15: 00FF, 00FD, 0008, 0000, 0001, 0003, 0001, 0002
  - After 15, the opcode wraps to 0 and the sequence repeats.
- Divide by zero: opcode 12, A=8'h02, B=8'h00, ex_sel 0 and 1 -> Y=16'hFFFF. A=8'd17, B=8'd5 -> Y=16'h0203.
- Signed vs unsigned:
  - A=8'hFE, B=8'h03, opcode 2: ex_sel=0 -> 16'h02FA; ex_sel=1 -> 16'hFFFA.
  - Opcode 15: ex_sel=0 -> 16'h0001; ex_sel=1 -> 16'h0004.
  - Opcode 11, B=1: ex_sel=0 -> 16'h007F; ex_sel=1 -> 16'h00FF.
- Wrap and extremes:
  - A=B=8'hFF, ex_sel=0: ADD -> 16'h01FE; MUL -> 16'hFE01.
  - A=8'h00, DEC, ex_sel=0 -> 16'hFFFF.
  - A=8'h80, B=8'hFF, DIV, ex_sel=1 -> 16'h0080.
- Mid-operation reset: assert init=0 between edges while Y is nonzero -> Y=0 immediately, before the next clk edge.
